// File: rtl/irq_controller.sv
// irq_controller: edge-triggered external interrupt controller with claim/complete
// handshake and an optional machine timer.
// Optional feature: define IRQ_TIMER_EN to build MTIME/MTIMECMP and interrupt[1].
// Register map (word index): 0 ENABLE, 1 PENDING, 2 CLAIM/COMPLETE,
// 3 MTIME, 4 MTIMECMP (timer build only); unmapped addresses read 0.

module irq_controller #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic [2:0]         addr,
    input  logic [31:0]        wdata,
    input  logic               we,
    input  logic               re,
    output logic [31:0]        rdata,
    output logic [1:0]         interrupt
);

    localparam int unsigned ID_W        = 4;
    localparam int unsigned SUPP_W      = 2;
    localparam int unsigned SUPP_CYCLES = 2;

    localparam logic [2:0] ADDR_ENABLE  = 3'd0;
    localparam logic [2:0] ADDR_PENDING = 3'd1;
    localparam logic [2:0] ADDR_CLAIM   = 3'd2;
`ifdef IRQ_TIMER_EN
    localparam logic [2:0] ADDR_MTIME    = 3'd3;
    localparam logic [2:0] ADDR_MTIMECMP = 3'd4;
`endif

    // Synchroniser, history and post-reset edge suppression
    logic [NUM_SRC-1:0] r_sync1;
    logic [NUM_SRC-1:0] r_sync2;
    logic [NUM_SRC-1:0] r_hist;
    logic [SUPP_W-1:0]  r_supp;

    // Controller state
    logic [NUM_SRC-1:0] r_enable;
    logic [NUM_SRC-1:0] r_pending;
    logic [ID_W-1:0]    r_inservice;
    logic [31:0]        r_rdata;
    logic               r_irq_ext;

    // Decoded access strobes (a simultaneous we/re is a write only)
    logic               w_rd;
    logic               w_wr_enable;
    logic               w_rd_claim;
    logic               w_wr_claim;
    logic [NUM_SRC-1:0] w_edge;
    logic [NUM_SRC-1:0] w_qual;
    logic [NUM_SRC-1:0] w_claim_mask;
    logic [ID_W-1:0]    w_claim_id;
    logic               w_claim_ok;
    logic               w_complete;
    logic [31:0]        w_rdata_mux;

    assign w_rd        = re & ~we;
    assign w_wr_enable = we && (addr == ADDR_ENABLE);
    assign w_rd_claim  = w_rd && (addr == ADDR_CLAIM);
    assign w_wr_claim  = we && (addr == ADDR_CLAIM);

    // Two-flop synchroniser plus history; history reloads from the first stage
    // while suppression runs so a source already high at reset is not an edge
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_hist  <= '0;
            r_supp  <= SUPP_W'(SUPP_CYCLES);
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
            if (r_supp != '0) begin
                r_hist <= r_sync1;
                r_supp <= r_supp - SUPP_W'(1);
            end else begin
                r_hist <= r_sync2;
            end
        end
    end

    // Rising-edge detect on the synchronised value, masked during suppression
    always_comb begin
        w_edge = '0;
        if (r_supp == '0) begin
            w_edge = r_sync2 & ~r_hist;
        end
    end

    // Lowest-numbered pending and enabled source wins the claim
    always_comb begin
        w_qual       = r_pending & r_enable;
        w_claim_id   = '0;
        w_claim_mask = '0;
        for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
            if (w_qual[i]) begin
                w_claim_id      = ID_W'(i + 1);
                w_claim_mask    = '0;
                w_claim_mask[i] = 1'b1;
            end
        end
        w_claim_ok = w_rd_claim && (r_inservice == '0) && (w_qual != '0);
        w_complete = w_wr_claim && (wdata == 32'(r_inservice));
    end

    // ENABLE register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_enable <= '0;
        end else if (w_wr_enable) begin
            r_enable <= wdata[NUM_SRC-1:0];
        end
    end

    // PENDING: claim clears the granted bit, a coincident edge re-sets it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending <= '0;
        end else if (w_claim_ok) begin
            r_pending <= (r_pending & ~w_claim_mask) | w_edge;
        end else begin
            r_pending <= r_pending | w_edge;
        end
    end

    // INSERVICE: set by a successful claim, cleared by a matching complete
    always_ff @(posedge clk) begin
        if (reset) begin
            r_inservice <= '0;
        end else if (w_claim_ok) begin
            r_inservice <= w_claim_id;
        end else if (w_complete) begin
            r_inservice <= '0;
        end
    end

    // External interrupt: something claimable and nothing in service
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_ext <= 1'b0;
        end else begin
            r_irq_ext <= (|(r_pending & r_enable)) && (r_inservice == '0);
        end
    end

`ifdef IRQ_TIMER_EN
    logic [31:0] r_mtime;
    logic [31:0] r_mtimecmp;
    logic        r_irq_tmr;
    logic        w_wr_mtime;
    logic        w_wr_mtimecmp;

    assign w_wr_mtime    = we && (addr == ADDR_MTIME);
    assign w_wr_mtimecmp = we && (addr == ADDR_MTIMECMP);

    // Free-running MTIME; a write loads instead of incrementing
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtime <= '0;
        end else if (w_wr_mtime) begin
            r_mtime <= wdata;
        end else begin
            r_mtime <= r_mtime + 32'd1;
        end
    end

    // MTIMECMP register, parked at the maximum after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mtimecmp <= 32'hFFFF_FFFF;
        end else if (w_wr_mtimecmp) begin
            r_mtimecmp <= wdata;
        end
    end

    // Level-sensitive timer interrupt from an unsigned compare
    always_ff @(posedge clk) begin
        if (reset) begin
            r_irq_tmr <= 1'b0;
        end else begin
            r_irq_tmr <= (r_mtime >= r_mtimecmp);
        end
    end
`else
    logic r_irq_tmr;
    assign r_irq_tmr = 1'b0;
`endif

    // Read data selection
    always_comb begin
        w_rdata_mux = '0;
        case (addr)
            ADDR_ENABLE:   w_rdata_mux = 32'(r_enable);
            ADDR_PENDING:  w_rdata_mux = 32'(r_pending);
            ADDR_CLAIM:    w_rdata_mux = w_claim_ok ? 32'(w_claim_id) : 32'd0;
`ifdef IRQ_TIMER_EN
            ADDR_MTIME:    w_rdata_mux = r_mtime;
            ADDR_MTIMECMP: w_rdata_mux = r_mtimecmp;
`endif
            default:       w_rdata_mux = '0;
        endcase
    end

    // Registered read data, held while no read is in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (w_rd) begin
            r_rdata <= w_rdata_mux;
        end
    end

    assign rdata     = r_rdata;
    assign interrupt = {r_irq_tmr, r_irq_ext};

endmodule

// File: tb/tb_irq_controller.sv
// Directed testbench for irq_controller; timer checks follow IRQ_TIMER_EN.

module tb_irq_controller;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_src;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic [1:0]  interrupt;

    int n_checks;
    int n_fail;
    logic [31:0] d;

    irq_controller #(.NUM_SRC(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_src   (irq_src),
        .addr      (addr),
        .wdata     (wdata),
        .we        (we),
        .re        (re),
        .rdata     (rdata),
        .interrupt (interrupt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle away from it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] v);
        addr = a; wdata = v; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] v);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        v = rdata;
    endtask

    // One-cycle source pulse; returns once PENDING has been updated
    task automatic pulse(input logic [3:0] m);
        irq_src = m;
        tick();
        irq_src = '0;
        ticks(2);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        reset = 1'b1; irq_src = '0; addr = '0; wdata = '0; we = 1'b0; re = 1'b0;
        ticks(2);
        reset = 1'b0;

        // Reset state
        chk("rst_interrupt", 32'(interrupt), 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        rd(3'd0, d); chk("rst_enable", d, 32'd0);
        rd(3'd1, d); chk("rst_pending", d, 32'd0);
`ifdef IRQ_TIMER_EN
        rd(3'd4, d); chk("rst_mtimecmp", d, 32'hFFFF_FFFF);
`else
        rd(3'd4, d); chk("rst_mtimecmp_absent", d, 32'd0);
`endif

        // Single source pulse through to claim
        wr(3'd0, 32'h1);
        irq_src = 4'h1;
        tick();
        irq_src = '0;
        tick();
        tick();
        chk("t1_int_before_e3", 32'(interrupt[0]), 32'd0);
        tick();
        chk("t1_int_after_e3", 32'(interrupt[0]), 32'd1);
        rd(3'd1, d); chk("t1_pending", d, 32'h1);
        rd(3'd2, d); chk("t1_claim", d, 32'd1);
        tick();
        chk("t1_int_cleared", 32'(interrupt[0]), 32'd0);
        wr(3'd2, 32'd1);

        // Priority and no nesting
        wr(3'd0, 32'hF);
        pulse(4'h5);
        tick();
        rd(3'd1, d); chk("t2_pending", d, 32'h5);
        rd(3'd2, d); chk("t2_claim1", d, 32'd1);
        rd(3'd2, d); chk("t2_claim_nested", d, 32'd0);
        rd(3'd1, d); chk("t2_pending_left", d, 32'h4);
        wr(3'd2, 32'd1);
        rd(3'd2, d); chk("t2_claim3", d, 32'd3);
        wr(3'd2, 32'd3);
        rd(3'd1, d); chk("t2_pending_empty", d, 32'h0);

        // Edge coinciding with its own claim
        pulse(4'h2);
        tick();
        chk("t3_int", 32'(interrupt[0]), 32'd1);
        irq_src = 4'h2;
        tick();
        irq_src = '0;
        tick();
        addr = 3'd2; re = 1'b1;
        tick();
        re = 1'b0;
        chk("t3_claim", rdata, 32'd2);
        rd(3'd1, d); chk("t3_pending_kept", d, 32'h2);
        chk("t3_int_inservice", 32'(interrupt[0]), 32'd0);
        wr(3'd2, 32'd2);
        rd(3'd2, d); chk("t3_claim_again", d, 32'd2);
        wr(3'd2, 32'd2);

        // Disabled source keeps pending; enabling raises interrupt
        wr(3'd0, 32'h0);
        pulse(4'h8);
        tick();
        chk("t4_int_disabled", 32'(interrupt[0]), 32'd0);
        rd(3'd1, d); chk("t4_pending", d, 32'h8);
        wr(3'd0, 32'h8);
        chk("t4_int_same_cycle", 32'(interrupt[0]), 32'd0);
        tick();
        chk("t4_int_enabled", 32'(interrupt[0]), 32'd1);
        rd(3'd2, d); chk("t4_claim", d, 32'd4);
        wr(3'd2, 32'd4);

        // Mismatching complete is ignored
        wr(3'd0, 32'hF);
        pulse(4'h1);
        rd(3'd2, d); chk("t5_claim1", d, 32'd1);
        wr(3'd2, 32'd3);
        pulse(4'h4);
        rd(3'd2, d); chk("t5_still_inservice", d, 32'd0);
        wr(3'd2, 32'd1);
        rd(3'd2, d); chk("t5_claim3", d, 32'd3);
        wr(3'd2, 32'd3);

        // Unmapped address, rdata hold, write-wins on we&re
        wr(3'd7, 32'hFFFF_FFFF);
        rd(3'd7, d); chk("t6_unmapped", d, 32'd0);
        rd(3'd0, d); chk("t6_enable", d, 32'hF);
        ticks(2);
        chk("t6_rdata_hold", rdata, 32'hF);
        addr = 3'd0; wdata = 32'h3; we = 1'b1; re = 1'b1;
        tick();
        we = 1'b0; re = 1'b0;
        chk("t6_we_re_no_read", rdata, 32'hF);
        rd(3'd0, d); chk("t6_we_re_written", d, 32'h3);
        wr(3'd0, 32'hF);

`ifdef IRQ_TIMER_EN
        // Timer wrap and compare
        wr(3'd4, 32'h0000_0004);
        wr(3'd3, 32'hFFFF_FFF0);
        rd(3'd3, d); chk("tm_mtime_loaded", d, 32'hFFFF_FFF0);
        chk("tm_int_high_prewrap", 32'(interrupt[1]), 32'd1);
        ticks(15);
        rd(3'd3, d); chk("tm_mtime_wrapped", d, 32'd0);
        chk("tm_int_low_after_wrap", 32'(interrupt[1]), 32'd0);
        ticks(3);
        chk("tm_int_low_at_3", 32'(interrupt[1]), 32'd0);
        tick();
        chk("tm_int_high_at_4", 32'(interrupt[1]), 32'd1);
        wr(3'd4, 32'hFFFF_FFFF);
        tick();
        chk("tm_int_cleared", 32'(interrupt[1]), 32'd0);
        rd(3'd4, d); chk("tm_mtimecmp_rd", d, 32'hFFFF_FFFF);
`else
        // Timer absent: writes ignored, reads zero
        wr(3'd4, 32'd0);
        tick();
        chk("nt_int1_zero", 32'(interrupt[1]), 32'd0);
        rd(3'd4, d); chk("nt_mtimecmp_zero", d, 32'd0);
        rd(3'd3, d); chk("nt_mtime_zero", d, 32'd0);
`endif

        // Reset mid-claim with INSERVICE=2, PENDING=0x5
        pulse(4'h6);
        rd(3'd2, d); chk("rs_claim2", d, 32'd2);
        pulse(4'h1);
        tick();
        chk("rs_int_no_nest", 32'(interrupt[0]), 32'd0);
        rd(3'd1, d); chk("rs_pending5", d, 32'h5);
        reset = 1'b1; irq_src = 4'h8;
        tick();
        reset = 1'b0;
        chk("rs_interrupt", 32'(interrupt), 32'd0);
        chk("rs_rdata", rdata, 32'd0);
        ticks(5);
        rd(3'd1, d); chk("rs_pending_held_src", d, 32'h0);
        rd(3'd0, d); chk("rs_enable", d, 32'h0);
`ifdef IRQ_TIMER_EN
        rd(3'd4, d); chk("rs_mtimecmp", d, 32'hFFFF_FFFF);
`endif
        irq_src = '0;
        wr(3'd0, 32'hF);
        pulse(4'h4);
        tick();
        chk("rs_int_after", 32'(interrupt[0]), 32'd1);
        rd(3'd2, d); chk("rs_inservice_cleared", d, 32'd3);
        wr(3'd2, 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
